// File: rtl/mod_sum_pkg.sv
// Shared definitions for the modulo-sum job controller: data width, clear length
// and the controller state encoding.
package mod_sum_pkg;

  localparam int WIDTH     = 8;
  localparam int CLEAR_LEN = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR0,
    S_CLR1,
    S_CLR2,
    S_CLR3,
    S_ACCUM,
    S_DRAIN,
    S_FOLD,
    S_WAIT,
    S_RESULT
  } state_t;

endpackage

// File: rtl/mod_sum_ctrl.sv
// Job controller for the two-stage modulo accumulation datapath (modulo_adder).
// Optional range checking of operands: define MOD_SUM_CTRL_RANGE_CHECK_EN.
module mod_sum_ctrl #(
  parameter int WIDTH = mod_sum_pkg::WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic [WIDTH-1:0] acc_a,
  output logic [WIDTH-1:0] acc_p_rev,
  input  logic [WIDTH-1:0] acc_sum
);
  import mod_sum_pkg::*;

  state_t           state_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             err_reg;
  logic [CNT_W-1:0] count_reg;
  logic             in_fire;
  logic             op_bad;

  assign in_fire = in_ready_reg && in_valid;

`ifdef MOD_SUM_CTRL_RANGE_CHECK_EN
  assign op_bad = (in_data >= p_reg);
`else
  assign op_bad = 1'b0;
`endif

  // Datapath drive is combinational: operands and the clear/fold feedback must
  // reach the adder in the same cycle they are accepted or observed.
  always_comb begin
    acc_a     = '0;
    acc_p_rev = ~p_reg;
    case (state_reg)
      S_IDLE: acc_p_rev = '0;
      S_CLR0, S_CLR1: begin
        // P=255: each chain becomes x + ~x = 255 which folds to 0.
        acc_p_rev = '0;
        acc_a     = ~acc_sum;
      end
      S_CLR2, S_CLR3: acc_p_rev = '0;
      S_ACCUM: if (in_fire && !op_bad) acc_a = in_data;
      S_FOLD:  acc_a = prev_reg;
      default: ;
    endcase
  end

  // Previous chain output, used to merge the odd chain into the even one.
  always_ff @(posedge clk) begin
    prev_reg <= acc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      p_reg         <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && (p != '0)) begin
            p_reg     <= p;
            count_reg <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= S_CLR0;
          end
        end
        S_CLR0: state_reg <= S_CLR1;
        S_CLR1: state_reg <= S_CLR2;
        S_CLR2: state_reg <= S_CLR3;
        S_CLR3: begin
          in_ready_reg <= 1'b1;
          state_reg    <= S_ACCUM;
        end
        S_ACCUM: begin
          if (in_fire) begin
            if (count_reg != {CNT_W{1'b1}}) count_reg <= count_reg + 1'b1;
            if (op_bad) err_reg <= 1'b1;
            if (in_last) begin
              in_ready_reg <= 1'b0;
              state_reg    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: state_reg <= S_FOLD;
        S_FOLD:  state_reg <= S_WAIT;
        S_WAIT:  state_reg <= S_RESULT;
        S_RESULT: begin
          // First RESULT cycle captures the folded sum; afterwards hold until taken.
          if (!out_valid_reg) begin
            out_data_reg  <= acc_sum;
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign count     = count_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mod_sum_ctrl.sv
// Self-checking bench for mod_sum_ctrl with a behavioural two-chain modulo datapath.
module tb_mod_sum_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
`ifdef MOD_SUM_CTRL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] p = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             err;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_p_rev;
  logic [WIDTH-1:0] acc_sum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_sum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .count(count), .err(err),
    .acc_a(acc_a), .acc_p_rev(acc_p_rev), .acc_sum(acc_sum)
  );

  // Datapath: mux(t+2) = (a(t) + mux(t)) mod P, registers start from arbitrary values.
  logic [WIDTH-1:0] dp_s1 = 8'hA7;
  logic [WIDTH-1:0] dp_mux = 8'h5E;
  always @(posedge clk) begin
    dp_s1  <= 8'((9'(acc_a) + 9'(dp_mux)) % {1'b0, ~acc_p_rev});
    dp_mux <= dp_s1;
  end
  assign acc_sum = dp_mux;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input int pv, input int ops[$], input int gaps[$], input int hold);
    int k;
    int sum;
    bit bad;
    logic [WIDTH-1:0] prev_exp;
    sum = 0;
    bad = 1'b0;
    prev_exp = ~8'(pv);
    foreach (ops[i]) begin
      if (ops[i] >= pv) bad = 1'b1;
      if (!(RC && ops[i] >= pv)) sum += ops[i];
    end
    start = 1'b1;
    p = 8'(pv);
    @(negedge clk);
    start = 1'b0;
    p = 8'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    k = 1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_latency", k, 5);
    chk("acc_p_rev_accum", 32'(acc_p_rev), 32'(prev_exp));
    foreach (ops[i]) begin
      for (int g = 0; g < gaps[i]; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 8'(ops[i]);
      in_last  = (i == ops.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
    chk("in_ready_after_last", 32'(in_ready), 0);
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_latency", k, 5);
    if (!(bad && !RC)) chk("out_data", 32'(out_data), sum % pv);
    chk("count", 32'(count), ops.size());
    chk("err", 32'(err), (RC && bad) ? 1 : 0);
    chk("busy_in_result", 32'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      p = 8'd3;
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      if (!(bad && !RC)) chk("hold_data", 32'(out_data), sum % pv);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 0);
    chk("busy_drop", 32'(busy), 0);
    $display("job p=%0d ops=%0d result=%0d expected=%0d count=%0d err=%0d",
             pv, ops.size(), out_data, sum % pv, count, err);
  endtask

  initial begin
    int k;
    int n;
    int pr;
    int ops[$];
    int gaps[$];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_acc_a", 32'(acc_a), 0);
    chk("rst_acc_p_rev", 32'(acc_p_rev), 0);

    run_job(13, '{12, 12, 12}, '{0, 0, 0}, 0);
    run_job(7, '{3, 5}, '{0, 2}, 0);
    run_job(11, '{5}, '{0}, 5);
    run_job(1, '{0}, '{0}, 0);

    // A zero modulus must not start a job.
    start = 1'b1;
    p = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("p0_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("p0_busy_later", 32'(busy), 0);
    chk("p0_in_ready", 32'(in_ready), 0);
    $display("job p=0 ignored busy=%0d", busy);

    run_job(10, '{15, 4}, '{0, 0}, 2);

    // Reset in the middle of accumulation, then a fresh job.
    start = 1'b1;
    p = 8'd13;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_in_ready_latency", k, 5);
    in_valid = 1'b1;
    in_data = 8'd12;
    @(negedge clk);
    in_data = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_acc_a", 32'(acc_a), 0);
    chk("midrst_acc_p_rev", 32'(acc_p_rev), 0);
    $display("reset during accumulate busy=%0d count=%0d", busy, count);
    run_job(200, '{199, 1}, '{0, 0}, 0);

    for (int j = 0; j < 8; j++) begin
      pr = $urandom_range(1, 255);
      n = $urandom_range(1, 9);
      ops.delete();
      gaps.delete();
      for (int i = 0; i < n; i++) begin
        ops.push_back($urandom_range(0, pr - 1));
        gaps.push_back($urandom_range(0, 2));
      end
      run_job(pr, ops, gaps, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
